// File: rtl/operand_tf_pkg.sv
// Shared types and widths for the operand transformer datapath.
// The scale vector sequencer uses its FSM encoding and the element/scale widths.
package operand_tf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  localparam int ELEM_W  = 8;
  localparam int SCALE_W = 8;

endpackage

// File: rtl/scale_vector_sequencer_rr_arbiter.sv
// Combinational round-robin grant: the first request at or above ptr wins, with wrap-around.
// The pointer register lives in the caller.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any_grant
);

  int cand;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    any_grant = 1'b0;
    cand      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!any_grant && (j == cand) && req[j]) begin
          any_grant = 1'b1;
          grant[j]  = 1'b1;
          grant_id  = ID_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/simple_multiplier.sv
// Scales one byte by a left shift, MSB-justifying the value when the shift would overflow.
// This block is purely combinational.
module simple_multiplier (
  input  logic [7:0] operand_in,
  input  logic [7:0] scale,
  output logic [7:0] result_out
);

  logic [2:0] lead_pos;
  logic [8:0] shift_sum;

  always_comb begin
    lead_pos = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (operand_in[i]) lead_pos = 3'(i);
    end
    shift_sum = {6'd0, lead_pos} + {1'b0, scale};
    if (operand_in == 8'd0) begin
      result_out = 8'd0;
    end else if (shift_sum <= 9'd7) begin
      result_out = operand_in << scale[2:0];
    end else begin
      result_out = operand_in << (3'd7 - lead_pos);
    end
  end

endmodule

// File: rtl/scale_vector_sequencer.sv
// Shares one simple_multiplier among NUM_REQ requesters: arbitrate, stream a vector
// through one element per cycle, and return the scaled vector tagged with its owner.
module scale_vector_sequencer
  import operand_tf_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int NUM_ELEM = 4,
  parameter int ID_W     = $clog2(NUM_REQ),
  parameter int IDX_W    = $clog2(NUM_ELEM) + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*NUM_ELEM*8-1:0] req_vec,
  input  logic [NUM_REQ*8-1:0]          req_scale,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [NUM_ELEM*8-1:0]         rsp_vec,
  output logic                          busy
);

  localparam int VEC_W = NUM_ELEM * ELEM_W;

  seq_state_e          state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    elem_idx_q, elem_idx_d;
  logic [VEC_W-1:0]    vec_q, vec_d;
  logic [SCALE_W-1:0]  scale_q, scale_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [VEC_W-1:0]    rsp_vec_q, rsp_vec_d;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_id;
  logic                any_grant;
  logic [VEC_W-1:0]    sel_vec;
  logic [SCALE_W-1:0]  sel_scale;
  logic [ELEM_W-1:0]   mult_in;
  logic [ELEM_W-1:0]   mult_out;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_id  (grant_id),
    .any_grant (any_grant)
  );

  simple_multiplier u_mult (
    .operand_in (mult_in),
    .scale      (scale_q),
    .result_out (mult_out)
  );

  always_comb begin
    sel_vec   = '0;
    sel_scale = '0;
    mult_in   = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (grant_id == ID_W'(r)) begin
        sel_vec   = req_vec[r*VEC_W +: VEC_W];
        sel_scale = req_scale[r*SCALE_W +: SCALE_W];
      end
    end
    for (int e = 0; e < NUM_ELEM; e++) begin
      if (elem_idx_q == IDX_W'(e)) mult_in = vec_q[e*ELEM_W +: ELEM_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    elem_idx_d = elem_idx_q;
    vec_d      = vec_q;
    scale_d    = scale_q;
    id_d       = id_q;
    rsp_vec_d  = rsp_vec_q;
    req_ready  = '0;
    unique case (state_q)
      IDLE: begin
        // Gating with rst_n keeps every grant low while reset is held.
        if (rst_n) req_ready = grant;
        if (any_grant) begin
          vec_d      = sel_vec;
          scale_d    = sel_scale;
          id_d       = grant_id;
          rr_ptr_d   = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
          elem_idx_d = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        for (int e = 0; e < NUM_ELEM; e++) begin
          if (elem_idx_q == IDX_W'(e)) rsp_vec_d[e*ELEM_W +: ELEM_W] = mult_out;
        end
        elem_idx_d = elem_idx_q + 1'b1;
        if (elem_idx_q == IDX_W'(NUM_ELEM - 1)) state_d = DONE;
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      elem_idx_q <= '0;
      vec_q      <= '0;
      scale_q    <= '0;
      id_q       <= '0;
      rsp_vec_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      elem_idx_q <= elem_idx_d;
      vec_q      <= vec_d;
      scale_q    <= scale_d;
      id_q       <= id_d;
      rsp_vec_q  <= rsp_vec_d;
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = id_q;
  assign rsp_vec   = rsp_vec_q;

endmodule

// File: tb/tb_scale_vector_sequencer.sv
// Directed bench for scale_vector_sequencer: driver pushes expected responses into a
// scoreboard queue and a monitor compares them at each response handshake.
module tb_scale_vector_sequencer;

  localparam int NUM_REQ  = 2;
  localparam int NUM_ELEM = 4;
  localparam int ID_W     = 1;
  localparam int IDX_W    = 3;

  localparam logic [31:0] A_VEC = 32'h0080_0301;
  localparam logic [31:0] A_EXP = 32'h0080_0C04;
  localparam logic [31:0] B_VEC = 32'h10FF_0105;
  localparam logic [31:0] B_EXP = 32'h80FF_80A0;
  localparam logic [31:0] C_VEC = 32'h0040_0201;
  localparam logic [31:0] C_EXP = 32'h0080_8080;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [63:0]          req_vec;
  logic [15:0]          req_scale;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [31:0]          rsp_vec;
  logic                 busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [32:0] sb[$];
  logic [32:0] mon_exp;

  scale_vector_sequencer #(
    .NUM_REQ  (NUM_REQ),
    .NUM_ELEM (NUM_ELEM),
    .ID_W     (ID_W),
    .IDX_W    (IDX_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_vec   (req_vec),
    .req_scale (req_scale),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_vec   (rsp_vec),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 64'(rsp_vec), 64'hDEAD);
      end else begin
        mon_exp = sb.pop_front();
        check("rsp_vec", 64'(rsp_vec), 64'(mon_exp[31:0]));
        check("rsp_id", 64'(rsp_id), 64'(mon_exp[32]));
      end
    end
  end

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic run_job(input int r, input logic [31:0] v, input logic [7:0] s,
                         input logic [31:0] ev);
    int n = 0;
    int lat = 0;
    @(negedge clk);
    req_vec[r*32 +: 32] = v;
    req_scale[r*8 +: 8] = s;
    req_valid[r]        = 1'b1;
    #1;
    while (req_ready[r] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("job_grant", 64'(req_ready[r]), 64'd1);
    sb.push_back({1'(r), ev});
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
    check("job_busy", 64'(busy), 64'd1);
    while (rsp_valid !== 1'b1 && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("job_latency", 64'(lat), 64'd4);
    wait_drain();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int last;
    logic [31:0] hold_vec;
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_vec   = {B_VEC, A_VEC};
    req_scale = {8'd7, 8'd2};
    rsp_ready = 1'b1;
    #12;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_vec", 64'(rsp_vec), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_no_req", 64'(req_ready), 64'd0);

    run_job(0, A_VEC, 8'd2, A_EXP);
    run_job(1, B_VEC, 8'd7, B_EXP);
    run_job(1, C_VEC, 8'd255, C_EXP);

    // Round-robin with both requesters always valid; pointer is 0 here.
    @(negedge clk);
    req_vec   = {B_VEC, A_VEC};
    req_scale = {8'd7, 8'd2};
    req_valid = 2'b11;
    last = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      #1;
      while (req_ready == 2'b00 && n < 50) begin
        @(negedge clk);
        #1;
        n++;
      end
      check("rr_grant", 64'(req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
      if (k % 2 == 0) sb.push_back({1'b0, A_EXP});
      else            sb.push_back({1'b1, B_EXP});
      if (k > 0) check("rr_spacing", 64'(cyc - last), 64'd6);
      last = cyc;
      @(posedge clk);
      #1;
      if (k == 3) req_valid = 2'b00;
      @(negedge clk);
    end
    wait_drain();

    // Backpressure: hold the response while r1 waits.
    rsp_ready = 1'b0;
    req_vec[31:0]  = A_VEC;
    req_scale[7:0] = 8'd2;
    req_valid      = 2'b01;
    #1;
    check("bp_grant", 64'(req_ready), 64'd1);
    sb.push_back({1'b0, A_EXP});
    @(posedge clk);
    #1;
    req_vec[63:32]  = B_VEC;
    req_scale[15:8] = 8'd7;
    req_valid       = 2'b10;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    hold_vec = rsp_vec;
    check("bp_vec_captured", 64'(hold_vec), 64'(A_EXP));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(rsp_valid), 64'd1);
      check("bp_vec", 64'(rsp_vec), 64'(A_EXP));
      check("bp_id", 64'(rsp_id), 64'd0);
      check("bp_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_valid_drop", 64'(rsp_valid), 64'd0);
    check("bp_next_grant", 64'(req_ready), 64'd2);
    sb.push_back({1'b1, B_EXP});
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    check("bp_accept", 64'(busy), 64'd1);
    wait_drain();

    // Reset in the middle of a job granted to r0 (pointer moves to 1).
    @(negedge clk);
    req_vec[31:0]  = A_VEC;
    req_scale[7:0] = 8'd2;
    req_valid      = 2'b01;
    #1;
    check("mid_grant", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_vec", 64'(rsp_vec), 64'd0);
    check("mid_rst_id", 64'(rsp_id), 64'd0);
    req_vec   = {B_VEC, A_VEC};
    req_scale = {8'd7, 8'd2};
    req_valid = 2'b11;
    #1;
    check("mid_rst_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_grant", 64'(req_ready), 64'd1);
    check("post_rst_valid", 64'(rsp_valid), 64'd0);
    sb.push_back({1'b0, A_EXP});
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
